// File: rtl/dvk_bus_pkg.sv
// Shared bus definitions for the DVK board: SDRAM transaction widths and
// the arbiter state encoding.
package dvk_bus_pkg;

    localparam int unsigned ADR_W = 21;
    localparam int unsigned DAT_W = 16;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned TMR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker. The registered grant doubles as the
// last-granted pointer, so a tie goes to the port not served last time.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic       pick,
    output logic       grant
);

    logic last_q;
    logic last_d;

    always_comb begin
        pick = 1'b0;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_q;
            default: pick = 1'b0;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (en) begin
            last_d = pick;
        end
    end

    // Resetting to port 1 makes port 0 win the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign grant = last_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the single SDRAM transaction port between the CPU (port 0) and a
// secondary master (port 1), with a timeout and a forced stb-low gap.
module sdram_arbiter
    import dvk_bus_pkg::*;
#(
    parameter int unsigned          TIMEOUT = 255,
    parameter logic [DAT_W-1:0]     ERRDATA = 16'hFFFF
) (
    input  logic             clk_p,
    input  logic             reset,
    input  logic             sdram_ready,
    input  logic             m0_stb,
    input  logic             m1_stb,
    input  logic             m0_we,
    input  logic             m1_we,
    input  logic [SEL_W-1:0] m0_sel,
    input  logic [SEL_W-1:0] m1_sel,
    input  logic [ADR_W-1:0] m0_adr,
    input  logic [ADR_W-1:0] m1_adr,
    input  logic [DAT_W-1:0] m0_out,
    input  logic [DAT_W-1:0] m1_out,
    output logic             m0_ack,
    output logic             m1_ack,
    output logic             m0_err,
    output logic             m1_err,
    output logic [DAT_W-1:0] m0_dat,
    output logic [DAT_W-1:0] m1_dat,
    output logic             sdram_stb,
    output logic             sdram_we,
    output logic [SEL_W-1:0] sdram_sel,
    output logic [ADR_W-1:0] sdram_adr,
    output logic [DAT_W-1:0] sdram_out,
    input  logic [DAT_W-1:0] sdram_dat,
    input  logic             sdram_ack
);

    localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(TIMEOUT - 1);

    arb_state_e state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             stb_q, stb_d;
    logic             we_q, we_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [DAT_W-1:0] out_q, out_d;
    logic [1:0]       ack_q, ack_d;
    logic [1:0]       err_q, err_d;
    logic [1:0][DAT_W-1:0] dat_q, dat_d;

    logic grant_en;
    logic pick;
    logic grant;
    logic grant_stb;

    assign grant_en  = (state_q == ST_IDLE) && sdram_ready && (m0_stb || m1_stb);
    assign grant_stb = grant ? m1_stb : m0_stb;

    rr_arb2 u_rr (
        .clk   (clk_p),
        .reset (reset),
        .en    (grant_en),
        .req   ({m1_stb, m0_stb}),
        .pick  (pick),
        .grant (grant)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        stb_d   = stb_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        out_d   = out_q;
        ack_d   = ack_q;
        err_d   = err_q;
        dat_d   = dat_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_en) begin
                    we_d    = pick ? m1_we  : m0_we;
                    sel_d   = pick ? m1_sel : m0_sel;
                    adr_d   = pick ? m1_adr : m0_adr;
                    out_d   = pick ? m1_out : m0_out;
                    stb_d   = 1'b1;
                    timer_d = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
                // Ack is tested first so it wins over a coincident timeout.
                if (sdram_ack) begin
                    stb_d        = 1'b0;
                    ack_d[grant] = 1'b1;
                    err_d[grant] = 1'b0;
                    dat_d[grant] = sdram_dat;
                    state_d      = ST_DONE;
                end else if (timer_q >= TO_LAST) begin
                    stb_d        = 1'b0;
                    ack_d[grant] = 1'b1;
                    err_d[grant] = 1'b1;
                    dat_d[grant] = ERRDATA;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!grant_stb) begin
                    ack_d   = '0;
                    err_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_p) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            out_q   <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            out_q   <= out_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    assign sdram_stb = stb_q;
    assign sdram_we  = we_q;
    assign sdram_sel = sel_q;
    assign sdram_adr = adr_q;
    assign sdram_out = out_q;
    assign m0_ack    = ack_q[0];
    assign m1_ack    = ack_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];
    assign m0_dat    = dat_q[0];
    assign m1_dat    = dat_q[1];

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter with a small SDRAM reply
// model whose ack delay and ack suppression are set per test.
module tb_sdram_arbiter;

    logic        clk_p = 1'b0;
    logic        reset = 1'b1;
    logic        sdram_ready = 1'b1;
    logic        m0_stb = 1'b0, m1_stb = 1'b0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic [1:0]  m0_sel = '0, m1_sel = '0;
    logic [20:0] m0_adr = '0, m1_adr = '0;
    logic [15:0] m0_out = '0, m1_out = '0;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [15:0] m0_dat, m1_dat;
    logic        sdram_stb, sdram_we;
    logic [1:0]  sdram_sel;
    logic [20:0] sdram_adr;
    logic [15:0] sdram_out;
    logic [15:0] sdram_dat;
    logic        sdram_ack;

    int n_total = 0;
    int n_bad   = 0;

    // SDRAM reply model: ack is combinational stb & reply, reply rises
    // mdl_delay edges after stb was first seen high.
    int          mdl_cnt = 0;
    int          mdl_delay = 1;
    bit          mdl_noack = 1'b0;
    logic [15:0] mdl_data = '0;

    assign sdram_ack = sdram_stb && !mdl_noack && (mdl_cnt == mdl_delay);
    assign sdram_dat = mdl_data;

    always @(posedge clk_p) mdl_cnt <= sdram_stb ? mdl_cnt + 1 : 0;

    always #5 clk_p = ~clk_p;

    sdram_arbiter #(.TIMEOUT(16), .ERRDATA(16'hFFFF)) dut (
        .clk_p       (clk_p),
        .reset       (reset),
        .sdram_ready (sdram_ready),
        .m0_stb      (m0_stb),
        .m1_stb      (m1_stb),
        .m0_we       (m0_we),
        .m1_we       (m1_we),
        .m0_sel      (m0_sel),
        .m1_sel      (m1_sel),
        .m0_adr      (m0_adr),
        .m1_adr      (m1_adr),
        .m0_out      (m0_out),
        .m1_out      (m1_out),
        .m0_ack      (m0_ack),
        .m1_ack      (m1_ack),
        .m0_err      (m0_err),
        .m1_err      (m1_err),
        .m0_dat      (m0_dat),
        .m1_dat      (m1_dat),
        .sdram_stb   (sdram_stb),
        .sdram_we    (sdram_we),
        .sdram_sel   (sdram_sel),
        .sdram_adr   (sdram_adr),
        .sdram_out   (sdram_out),
        .sdram_dat   (sdram_dat),
        .sdram_ack   (sdram_ack)
    );

    // Downstream monitor, sampled on the inactive edge.
    bit          prev_stb = 1'b0;
    logic [39:0] prev_bus = '0;
    int          cur_len = 0, last_len = 0, low_len = 0, min_low = 1000;
    int          n_rise = 0, unstable = 0, m1_ack_cnt = 0;
    logic        rise_we;
    logic [1:0]  rise_sel;
    logic [20:0] rise_adr;
    logic [15:0] rise_out;
    bit          rise_port[$];

    always @(negedge clk_p) begin
        if (sdram_stb && !prev_stb) begin
            rise_we  <= sdram_we;
            rise_sel <= sdram_sel;
            rise_adr <= sdram_adr;
            rise_out <= sdram_out;
            rise_port.push_back(sdram_adr[20]);
            cur_len  <= 1;
            n_rise   <= n_rise + 1;
            if (n_rise > 0 && low_len < min_low) min_low <= low_len;
        end else if (sdram_stb) begin
            cur_len <= cur_len + 1;
            if ({sdram_we, sdram_sel, sdram_adr, sdram_out} !== prev_bus) unstable <= unstable + 1;
        end
        if (!sdram_stb && prev_stb) begin
            last_len <= cur_len;
            low_len  <= 1;
        end else if (!sdram_stb) begin
            low_len <= low_len + 1;
        end
        if (m1_ack) m1_ack_cnt <= m1_ack_cnt + 1;
        prev_stb <= sdram_stb;
        prev_bus <= {sdram_we, sdram_sel, sdram_adr, sdram_out};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask

    // One master transaction: raise stb, wait (bounded) for ack, capture,
    // drop stb and hold it low across one edge.
    task automatic m_txn(input bit p, input bit we, input logic [1:0] sel,
                         input logic [20:0] adr, input logic [15:0] out,
                         output logic [15:0] dat, output logic err, output int lat);
        int t_sack;
        bit done;
        t_sack = -1;
        lat    = -1;
        done   = 1'b0;
        dat    = '0;
        err    = 1'b0;
        if (p) begin
            m1_we = we; m1_sel = sel; m1_adr = adr; m1_out = out; m1_stb = 1'b1;
        end else begin
            m0_we = we; m0_sel = sel; m0_adr = adr; m0_out = out; m0_stb = 1'b1;
        end
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            if (sdram_ack && t_sack < 0) t_sack = i;
            if (p ? m1_ack : m0_ack) begin
                done = 1'b1;
                dat  = p ? m1_dat : m0_dat;
                err  = p ? m1_err : m0_err;
                lat  = i - t_sack;
            end
        end
        check_eq(p ? "m1_ack_arrives" : "m0_ack_arrives", done, 1);
        if (p) m1_stb = 1'b0;
        else   m0_stb = 1'b0;
        tick();
    endtask

    logic [15:0] t_dat, c0_dat, c1_dat;
    logic        t_err, c0_err, c1_err;
    int          t_lat, c0_lat, c1_lat;
    int          base, m1_base, n_hi;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (3) tick();
        check_eq("rst_stb", sdram_stb, 0);
        check_eq("rst_acks", {m0_ack, m1_ack, m0_err, m1_err, sdram_we}, 0);
        check_eq("rst_bus", {sdram_sel, sdram_adr, sdram_out}, 0);
        check_eq("rst_dat", {m0_dat, m1_dat}, 0);
        reset = 1'b0;
        tick();

        // Single read on port 0, ack after 3 cycles
        mdl_delay = 3;
        mdl_data  = 16'h1234;
        m1_base   = m1_ack_cnt;
        m_txn(0, 0, 2'b11, 21'h001000, 16'h0000, t_dat, t_err, t_lat);
        check_eq("rd0_dat", t_dat, 16'h1234);
        check_eq("rd0_err", t_err, 0);
        check_eq("rd0_adr", rise_adr, 21'h001000);
        check_eq("rd0_we", rise_we, 0);
        check_eq("rd0_stb_len", last_len, 4);
        check_eq("rd0_lat", t_lat, 1);
        check_eq("rd0_no_m1_ack", m1_ack_cnt - m1_base, 0);

        // Byte write on port 1, ack after 1 cycle
        mdl_delay = 1;
        mdl_data  = 16'h7777;
        m_txn(1, 1, 2'b10, 21'h100040, 16'hAB00, t_dat, t_err, t_lat);
        check_eq("wr1_we", rise_we, 1);
        check_eq("wr1_sel", rise_sel, 2'b10);
        check_eq("wr1_adr", rise_adr, 21'h100040);
        check_eq("wr1_out", rise_out, 16'hAB00);
        check_eq("wr1_stable", unstable, 0);
        check_eq("wr1_lat", t_lat, 1);
        check_eq("wr1_err", t_err, 0);
        check_eq("wr1_stb_len", last_len, 2);

        // Both masters requesting continuously: grants alternate from port 0
        mdl_data = 16'hC0DE;
        base     = rise_port.size();
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    m_txn(0, 0, 2'b11, 21'h000010 + 21'(k), 16'h0000, c0_dat, c0_err, c0_lat);
                    check_eq("cont_m0_dat", c0_dat, 16'hC0DE);
                end
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    m_txn(1, 0, 2'b11, 21'h100010 + 21'(k), 16'h0000, c1_dat, c1_err, c1_lat);
                    check_eq("cont_m1_dat", c1_dat, 16'hC0DE);
                end
            end
        join
        check_eq("cont_count", rise_port.size() - base, 6);
        for (int k = 0; k < 6; k++) begin
            if (base + k < rise_port.size())
                check_eq("cont_order", rise_port[base + k], k % 2);
        end
        check_eq("cont_gap", min_low >= 1, 1);
        check_eq("cont_stable", unstable, 0);

        // Timeout on port 0, then a normal transaction
        mdl_noack = 1'b1;
        m_txn(0, 0, 2'b01, 21'h000AAA, 16'h0000, t_dat, t_err, t_lat);
        check_eq("to_err", t_err, 1);
        check_eq("to_dat", t_dat, 16'hFFFF);
        check_eq("to_stb_len", last_len, 16);
        mdl_noack = 1'b0;
        mdl_delay = 2;
        mdl_data  = 16'h5A5A;
        m_txn(0, 0, 2'b11, 21'h000BBB, 16'h0000, t_dat, t_err, t_lat);
        check_eq("post_to_dat", t_dat, 16'h5A5A);
        check_eq("post_to_err", t_err, 0);

        // Port 1 read so the last pointer is back on port 1
        mdl_delay = 1;
        mdl_data  = 16'h0F0F;
        m_txn(1, 0, 2'b11, 21'h100ABC, 16'h0000, t_dat, t_err, t_lat);
        check_eq("rd1_dat", t_dat, 16'h0F0F);

        // sdram_ready low blocks grants; raising it grants port 0
        mdl_noack   = 1'b1;
        sdram_ready = 1'b0;
        m0_adr = 21'h000111; m0_we = 1'b0; m0_sel = 2'b11; m0_stb = 1'b1;
        m1_adr = 21'h100222; m1_we = 1'b0; m1_sel = 2'b11; m1_stb = 1'b1;
        n_hi = 0;
        repeat (50) begin
            tick();
            if (sdram_stb) n_hi++;
        end
        check_eq("notready_no_stb", n_hi, 0);
        sdram_ready = 1'b1;
        tick();
        check_eq("ready_stb", sdram_stb, 1);
        check_eq("ready_grant0", sdram_adr, 21'h000111);

        // Reset mid-BUSY
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_eq("midrst_stb", sdram_stb, 0);
        check_eq("midrst_acks", {m0_ack, m1_ack, m0_err, m1_err, sdram_we}, 0);
        check_eq("midrst_bus", {sdram_sel, sdram_adr, sdram_out}, 0);
        check_eq("midrst_dat", {m0_dat, m1_dat}, 0);
        reset = 1'b0;
        tick();
        check_eq("postrst_stb", sdram_stb, 1);
        check_eq("postrst_grant0", sdram_adr, 21'h000111);
        m0_stb    = 1'b0;
        m1_stb    = 1'b0;
        mdl_noack = 1'b0;
        repeat (30) tick();
        check_eq("final_idle_stb", sdram_stb, 0);
        check_eq("final_idle_ack", {m0_ack, m1_ack}, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
